// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default datapath sizes, pooling FSM states and a
// per-channel signed max over packed channel vectors.
package cnn_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CH_NUM     = 18;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } pool_state_t;

    function automatic logic [CH_NUM*DATA_WIDTH-1:0] vec_max(
        input logic [CH_NUM*DATA_WIDTH-1:0] a,
        input logic [CH_NUM*DATA_WIDTH-1:0] b
    );
        logic [CH_NUM*DATA_WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            res[k*DATA_WIDTH +: DATA_WIDTH] =
                ($signed(a[k*DATA_WIDTH +: DATA_WIDTH]) > $signed(b[k*DATA_WIDTH +: DATA_WIDTH]))
                ? a[k*DATA_WIDTH +: DATA_WIDTH] : b[k*DATA_WIDTH +: DATA_WIDTH];
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer holding one row of horizontal maxima; one write, one read port.
// Latency: read data registered, valid 1 cycle after re, held until the next re.
// Backpressure: none; write and read are accepted every cycle.
module pool_line_buffer #(
    parameter int DEPTH  = 160,
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 144
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pool_unit.sv
// 2x2 stride-2 signed max-pool with per-frame bypass; POOL_RELU_EN clamps inputs at 0.
// Latency: output 1 cycle after the odd-row/odd-col beat (after every beat in bypass).
// Backpressure: none; every valid beat is accepted and the output has no ready.
module pool_unit #(
    parameter int CH_NUM      = cnn_pkg::CH_NUM,
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter int MAX_ROW_LEN = 320,
    parameter int COL_W       = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [COL_W-1:0]             row_len,
    input  logic                         pool_bypass,
    input  logic [CH_NUM*DATA_WIDTH-1:0] Pool_data_in,
    input  logic                         Pool_data_valid_in,
    output logic [CH_NUM*DATA_WIDTH-1:0] Pool_data_out,
    output logic                         Pool_data_valid_out,
    output logic                         row_done
);
    import cnn_pkg::*;

    localparam int VW = CH_NUM * DATA_WIDTH;
    localparam int AW = COL_W - 1;

    pool_state_t      state, state_nxt, cur_state;
    logic [COL_W-1:0] col, col_nxt, cur_col, len_q, cur_len;
    logic             bypass_q, cur_bypass;
    logic [VW-1:0]    pixel, pair_reg, lb_q, hmax;
    logic             beat, last_col, odd_col, lb_we, lb_re, out_fire, row_end;

`ifdef POOL_RELU_EN
    for (genvar k = 0; k < CH_NUM; k++) begin : g_relu
        assign pixel[k*DATA_WIDTH +: DATA_WIDTH] = Pool_data_in[k*DATA_WIDTH + DATA_WIDTH - 1]
            ? '0 : Pool_data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    assign pixel = Pool_data_in;
`endif

    // A frame_start beat is processed as row 0, col 0 under the new configuration.
    always_comb begin
        cur_state  = frame_start ? EVEN_ROW : state;
        cur_col    = frame_start ? '0 : col;
        cur_len    = frame_start ? row_len : len_q;
        cur_bypass = frame_start ? pool_bypass : bypass_q;
        beat       = Pool_data_valid_in && (cur_state != IDLE);
        last_col   = (cur_col == cur_len - COL_W'(1));
        odd_col    = cur_col[0];
        state_nxt  = cur_state;
        col_nxt    = cur_col;
        if (beat) begin
            col_nxt = last_col ? '0 : cur_col + COL_W'(1);
            if (last_col) state_nxt = (cur_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
        end
    end

    assign hmax     = vec_max(pair_reg, pixel);
    assign lb_we    = beat && !cur_bypass && (cur_state == EVEN_ROW) && odd_col;
    // Even col c reads address (c+1)>>1 == c>>1; a trailing odd-length column has no partner.
    assign lb_re    = beat && !cur_bypass && (cur_state == ODD_ROW) && !odd_col && !last_col;
    assign out_fire = beat && (cur_bypass || ((cur_state == ODD_ROW) && odd_col));
    // Last pooled output of a row sits at col len-1 (even len) or len-2 (odd len).
    assign row_end  = cur_bypass ? last_col
                    : ({1'b0, cur_col} + (COL_W+1)'(2) >= {1'b0, cur_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q               <= '0;
            bypass_q            <= 1'b0;
            pair_reg            <= '0;
            Pool_data_out       <= '0;
            Pool_data_valid_out <= 1'b0;
            row_done            <= 1'b0;
        end else begin
            if (frame_start) begin
                len_q    <= row_len;
                bypass_q <= pool_bypass;
            end
            if (beat && !odd_col && !cur_bypass) pair_reg <= pixel;
            Pool_data_valid_out <= out_fire;
            row_done            <= out_fire && row_end;
            if (out_fire) Pool_data_out <= cur_bypass ? pixel : vec_max(hmax, lb_q);
        end
    end

    pool_line_buffer #(
        .DEPTH  (MAX_ROW_LEN / 2),
        .ADDR_W (AW),
        .WIDTH  (VW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (cur_col[COL_W-1:1]),
        .wdata (hmax),
        .re    (lb_re),
        .raddr (cur_col[COL_W-1:1]),
        .rdata (lb_q)
    );

endmodule

// File: tb/tb_pool_unit.sv
// Directed bench for pool_unit: 4x4 pooling, negative data, odd row length,
// valid gaps, bypass, mid-frame restart and reset.
module tb_pool_unit;
    localparam int CH = 18;
    localparam int DW = 8;
    localparam int VW = CH * DW;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pool_bypass = 1'b0;
    logic          vin = 1'b0;
    logic [CW-1:0] row_len = '0;
    logic [VW-1:0] din = '0;
    logic [VW-1:0] dout;
    logic          vout;
    logic          row_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [VW-1:0] q_dat[$];
    int            q_cyc[$];
    bit            q_done[$];
    int            exp_cyc[$];

    pool_unit #(.CH_NUM(CH), .DATA_WIDTH(DW), .MAX_ROW_LEN(320), .COL_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .row_len             (row_len),
        .pool_bypass         (pool_bypass),
        .Pool_data_in        (din),
        .Pool_data_valid_in  (vin),
        .Pool_data_out       (dout),
        .Pool_data_valid_out (vout),
        .row_done            (row_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vout === 1'b1) begin
            q_dat.push_back(dout);
            q_cyc.push_back(cyc);
            q_done.push_back(row_done === 1'b1);
        end
    end

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        for (int k = 0; k < CH; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    task automatic step(input logic v, input logic [VW-1:0] d, input logic fs, output int c);
        @(negedge clk);
        vin = v;
        din = d;
        frame_start = fs;
        c = cyc;
    endtask

    task automatic idle(input int n);
        int c;
        repeat (n) step(1'b0, '0, 1'b0, c);
    endtask

    task automatic clear_q();
        q_dat.delete();
        q_cyc.delete();
        q_done.delete();
    endtask

    task automatic send_4x4(input bit gaps, input bit fs_first);
        int c;
        exp_cyc.delete();
        row_len = 9'd4;
        pool_bypass = 1'b0;
        if (!fs_first) step(1'b0, '0, 1'b1, c);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'b0, c);
                step(1'b1, fill(r*4 + k), fs_first && r == 0 && k == 0, c);
                if (r % 2 == 1 && k % 2 == 1) exp_cyc.push_back(c + 1);
            end
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vout); end
        checks++;
        if (row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done got %b want 0", row_done); end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dout); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_4x4();
        int exp_v[4] = '{5, 7, 13, 15};
        clear_q();
        send_4x4(1'b0, 1'b0);
        checks++;
        if (q_dat.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", q_dat.size()); end
        for (int i = 0; i < q_dat.size() && i < 4; i++) begin
            checks++;
            if (q_dat[i] !== fill(exp_v[i])) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, q_dat[i], fill(exp_v[i])); end
            checks++;
            if (q_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL basic_latency[%0d] got cycle %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
            checks++;
            if (q_done[i] !== (i % 2 == 1)) begin errors++; $display("FAIL basic_row_done[%0d] got %b want %b", i, q_done[i], (i % 2 == 1)); end
        end
    endtask

    task automatic test_negative();
        int c;
        int v0[4]  = '{-128, -3, -50, -7};
        int v1[4]  = '{1, 2, 3, 4};
        int v17[4] = '{-1, -2, -3, -4};
        logic [VW-1:0] p;
        logic [VW-1:0] expv;
        clear_q();
        row_len = 9'd2;
        pool_bypass = 1'b0;
        step(1'b0, '0, 1'b1, c);
        for (int i = 0; i < 4; i++) begin
            p = '0;
            p[0 +: DW]     = DW'(v0[i]);
            p[DW +: DW]    = DW'(v1[i]);
            p[17*DW +: DW] = DW'(v17[i]);
            step(1'b1, p, 1'b0, c);
        end
        idle(3);
        expv = '0;
`ifdef POOL_RELU_EN
        expv[DW +: DW] = 8'd4;
`else
        expv[0 +: DW]     = 8'hFD;
        expv[DW +: DW]    = 8'd4;
        expv[17*DW +: DW] = 8'hFF;
`endif
        checks++;
        if (q_dat.size() != 1) begin errors++; $display("FAIL neg_count got %0d want 1", q_dat.size()); end
        if (q_dat.size() > 0) begin
            checks++;
            if (q_dat[0] !== expv) begin errors++; $display("FAIL neg_data got %h want %h", q_dat[0], expv); end
            checks++;
            if (q_done[0] !== 1'b1) begin errors++; $display("FAIL neg_row_done got %b want 1", q_done[0]); end
        end
    endtask

    task automatic test_odd_len();
        int c;
        int exp_v[2] = '{7, 9};
        clear_q();
        exp_cyc.delete();
        row_len = 9'd5;
        pool_bypass = 1'b0;
        step(1'b0, '0, 1'b1, c);
        for (int v = 1; v <= 10; v++) begin
            step(1'b1, fill(v), 1'b0, c);
            if (v == 7 || v == 9) exp_cyc.push_back(c + 1);
        end
        idle(3);
        checks++;
        if (q_dat.size() != 2) begin errors++; $display("FAIL odd_count got %0d want 2", q_dat.size()); end
        for (int i = 0; i < q_dat.size() && i < 2; i++) begin
            checks++;
            if (q_dat[i] !== fill(exp_v[i])) begin errors++; $display("FAIL odd_data[%0d] got %h want %h", i, q_dat[i], fill(exp_v[i])); end
            checks++;
            if (q_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL odd_latency[%0d] got cycle %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
            checks++;
            if (q_done[i] !== (i == 1)) begin errors++; $display("FAIL odd_row_done[%0d] got %b want %b", i, q_done[i], (i == 1)); end
        end
    endtask

    task automatic test_gaps();
        int exp_v[4] = '{5, 7, 13, 15};
        clear_q();
        send_4x4(1'b1, 1'b1);
        checks++;
        if (q_dat.size() != 4) begin errors++; $display("FAIL gaps_count got %0d want 4", q_dat.size()); end
        for (int i = 0; i < q_dat.size() && i < 4; i++) begin
            checks++;
            if (q_dat[i] !== fill(exp_v[i])) begin errors++; $display("FAIL gaps_data[%0d] got %h want %h", i, q_dat[i], fill(exp_v[i])); end
            checks++;
            if (q_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL gaps_latency[%0d] got cycle %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
            checks++;
            if (q_done[i] !== (i % 2 == 1)) begin errors++; $display("FAIL gaps_row_done[%0d] got %b want %b", i, q_done[i], (i % 2 == 1)); end
        end
    endtask

    task automatic test_bypass();
        int c;
        clear_q();
        exp_cyc.delete();
        row_len = 9'd3;
        pool_bypass = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, fill(10 + i), i == 0, c);
            exp_cyc.push_back(c + 1);
        end
        idle(3);
        pool_bypass = 1'b0;
        checks++;
        if (q_dat.size() != 6) begin errors++; $display("FAIL bypass_count got %0d want 6", q_dat.size()); end
        for (int i = 0; i < q_dat.size() && i < 6; i++) begin
            checks++;
            if (q_dat[i] !== fill(10 + i)) begin errors++; $display("FAIL bypass_data[%0d] got %h want %h", i, q_dat[i], fill(10 + i)); end
            checks++;
            if (q_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL bypass_latency[%0d] got cycle %0d want %0d", i, q_cyc[i], exp_cyc[i]); end
            checks++;
            if (q_done[i] !== (i == 2 || i == 5)) begin errors++; $display("FAIL bypass_row_done[%0d] got %b want %b", i, q_done[i], (i == 2 || i == 5)); end
        end
    endtask

    task automatic test_mid_frame_start();
        int c;
        int exp_v[4] = '{5, 7, 13, 15};
        clear_q();
        row_len = 9'd4;
        pool_bypass = 1'b0;
        step(1'b0, '0, 1'b1, c);
        for (int k = 0; k < 4; k++) step(1'b1, fill(100 + k), 1'b0, c);
        step(1'b1, fill(120), 1'b0, c);
        send_4x4(1'b0, 1'b1);
        checks++;
        if (q_dat.size() != 4) begin errors++; $display("FAIL midframe_count got %0d want 4", q_dat.size()); end
        for (int i = 0; i < q_dat.size() && i < 4; i++) begin
            checks++;
            if (q_dat[i] !== fill(exp_v[i])) begin errors++; $display("FAIL midframe_data[%0d] got %h want %h", i, q_dat[i], fill(exp_v[i])); end
            checks++;
            if (q_done[i] !== (i % 2 == 1)) begin errors++; $display("FAIL midframe_row_done[%0d] got %b want %b", i, q_done[i], (i % 2 == 1)); end
        end
    endtask

    task automatic test_reset_mid_row();
        int c;
        clear_q();
        row_len = 9'd4;
        pool_bypass = 1'b0;
        step(1'b0, '0, 1'b1, c);
        for (int v = 0; v < 5; v++) step(1'b1, fill(v), 1'b0, c);
        step(1'b1, fill(5), 1'b0, c);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, c);
        checks++;
        if (vout !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", vout); end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", dout); end
        checks++;
        if (row_done !== 1'b0) begin errors++; $display("FAIL rstmid_row_done got %b want 0", row_done); end
        rst = 1'b0;
        for (int v = 0; v < 8; v++) step(1'b1, fill(v), 1'b0, c);
        idle(3);
        checks++;
        if (q_dat.size() != 0) begin errors++; $display("FAIL rstmid_idle_outputs got %0d want 0", q_dat.size()); end
        clear_q();
        send_4x4(1'b0, 1'b0);
        checks++;
        if (q_dat.size() != 4) begin errors++; $display("FAIL rstmid_refresh_count got %0d want 4", q_dat.size()); end
        if (q_dat.size() == 4) begin
            checks++;
            if (q_dat[3] !== fill(15)) begin errors++; $display("FAIL rstmid_refresh_data got %h want %h", q_dat[3], fill(15)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_negative();
        test_odd_len();
        test_gaps();
        test_bypass();
        test_mid_frame_start();
        test_reset_mid_row();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
